// File: rtl/fighter_motion_fsm_if.sv
// Key-level inputs and renderer-facing outputs of one fighter's motion FSM.
interface fighter_motion_fsm_if;
  logic       tick;
  logic       fwd;
  logic       bwd;
  logic       attack;
  logic       up;
  logic [9:0] pos_x;
  logic [7:0] pos_y;
  logic [2:0] state;
  logic       hit_active;
  logic       busy;

  modport master (
    output tick, fwd, bwd, attack, up,
    input  pos_x, pos_y, state, hit_active, busy
  );

  modport slave (
    input  tick, fwd, bwd, attack, up,
    output pos_x, pos_y, state, hit_active, busy
  );
endinterface

// File: rtl/fighter_motion_fsm.sv
// Per-player motion/action FSM: walk, jump with air control, three-phase attack.
module fighter_motion_fsm #(
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 600,
  parameter int unsigned X_INIT       = 100,
  parameter int unsigned STEP         = 2,
  parameter int unsigned JUMP_H       = 64,
  parameter int unsigned JUMP_STEP    = 4,
  parameter int unsigned WINDUP_T     = 3,
  parameter int unsigned ACTIVE_T     = 4,
  parameter int unsigned RECOVER_T    = 6,
  parameter int unsigned FACING_RIGHT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fighter_motion_fsm_if.slave  bus
);

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 8;
  localparam int unsigned CNT_W = 8;

  localparam logic [X_W:0] X_MIN_W  = (X_W+1)'(X_MIN);
  localparam logic [X_W:0] X_MAX_W  = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] STEP_W   = (X_W+1)'(STEP);
  localparam logic [Y_W:0] JUMP_H_W = (Y_W+1)'(JUMP_H);
  localparam logic [Y_W:0] JSTEP_W  = (Y_W+1)'(JUMP_STEP);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WALK    = 3'd1,
    JUMP_UP = 3'd2,
    JUMP_DN = 3'd3,
    WINDUP  = 3'd4,
    HIT     = 3'd5,
    RECOVER = 3'd6
  } state_t;

  state_t             state_q, state_n;
  logic [X_W-1:0]     pos_x_q, pos_x_n;
  logic [Y_W-1:0]     pos_y_q, pos_y_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               hit_q, hit_n;
  logic               busy_q, busy_n;
  logic               attack_d_q;
  logic               atk_req_q, atk_req_n;

  logic               atk_now;
  logic               fwd_only, bwd_only, move_pos, move_neg;
  logic [X_W:0]       x_ext, x_plus, x_minus;
  logic [X_W-1:0]     x_air;
  logic [Y_W:0]       y_ext, y_up, y_dn;
  logic [CNT_W-1:0]   cnt_inc;

  // Edge-qualified attack request; an edge coincident with tick counts for that tick.
  assign atk_now = atk_req_q | (bus.attack & ~attack_d_q);

  // Direction decode and saturating x/y arithmetic, widened by one bit to avoid wrap.
  always_comb begin
    fwd_only = bus.fwd & ~bus.bwd;
    bwd_only = bus.bwd & ~bus.fwd;
    move_pos = (FACING_RIGHT != 0) ? fwd_only : bwd_only;
    move_neg = (FACING_RIGHT != 0) ? bwd_only : fwd_only;
    x_ext    = {1'b0, pos_x_q};
    x_plus   = (x_ext > X_MAX_W - STEP_W) ? X_MAX_W : x_ext + STEP_W;
    x_minus  = (x_ext < X_MIN_W + STEP_W) ? X_MIN_W : x_ext - STEP_W;
    if (move_pos)      x_air = X_W'(x_plus);
    else if (move_neg) x_air = X_W'(x_minus);
    else               x_air = pos_x_q;
    y_ext    = {1'b0, pos_y_q};
    y_up     = (y_ext > JUMP_H_W - JSTEP_W) ? JUMP_H_W : y_ext + JSTEP_W;
    y_dn     = (y_ext < JSTEP_W) ? '0 : y_ext - JSTEP_W;
    cnt_inc  = cnt_q + CNT_W'(1);
  end

  // Next-state and next-output logic; everything advances only on tick.
  always_comb begin
    state_n   = state_q;
    pos_x_n   = pos_x_q;
    pos_y_n   = pos_y_q;
    cnt_n     = cnt_q;
    atk_req_n = atk_now;
    if (bus.tick) begin
      atk_req_n = 1'b0;
      unique case (state_q)
        IDLE, WALK: begin
          if (atk_now) begin
            state_n = WINDUP;
            cnt_n   = '0;
          end else if (bus.up) begin
            state_n = JUMP_UP;
          end else if (move_pos | move_neg) begin
            state_n = WALK;
            pos_x_n = x_air;
          end else begin
            state_n = IDLE;
          end
        end
        JUMP_UP: begin
          pos_x_n = x_air;
          pos_y_n = Y_W'(y_up);
          if (y_up == JUMP_H_W) state_n = JUMP_DN;
        end
        JUMP_DN: begin
          pos_x_n = x_air;
          pos_y_n = Y_W'(y_dn);
          if (y_dn == '0) state_n = IDLE;
        end
        WINDUP: begin
          if (cnt_inc == CNT_W'(WINDUP_T)) begin
            state_n = HIT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        HIT: begin
          if (cnt_inc == CNT_W'(ACTIVE_T)) begin
            state_n = RECOVER;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        RECOVER: begin
          if (cnt_inc == CNT_W'(RECOVER_T)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
    hit_n  = (state_n == HIT);
    busy_n = (state_n != IDLE) && (state_n != WALK);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pos_x_q    <= X_W'(X_INIT);
      pos_y_q    <= '0;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      busy_q     <= 1'b0;
      attack_d_q <= 1'b0;
      atk_req_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      pos_x_q    <= pos_x_n;
      pos_y_q    <= pos_y_n;
      cnt_q      <= cnt_n;
      hit_q      <= hit_n;
      busy_q     <= busy_n;
      attack_d_q <= bus.attack;
      atk_req_q  <= atk_req_n;
    end
  end

  assign bus.pos_x      = pos_x_q;
  assign bus.pos_y      = pos_y_q;
  assign bus.state      = state_q;
  assign bus.hit_active = hit_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/fighter_motion_fsm.md
# fighter_motion_fsm

Per-player motion and action state machine sitting directly downstream of the keypad scanner. It consumes the four registered key levels (`fwd`, `bwd`, `attack`, `up`) and advances once per game-frame `tick`. It produces the fighter's horizontal position, jump height, action state and hit-window flag for the renderer and the collision/damage logic.

## Interface
- `X_MIN`, default 0: leftmost legal x position.
- `X_MAX`, default 600: rightmost legal x position.
- `X_INIT`, default 100: x position after reset.
- `STEP`, default 2: x pixels moved per tick while walking.
- `JUMP_H`, default 64: apex height of a jump.
- `JUMP_STEP`, default 4: y pixels moved per tick during a jump.
- `WINDUP_T`, default 3: attack wind-up duration, in ticks.
- `ACTIVE_T`, default 4: attack hit-window duration, in ticks.
- `RECOVER_T`, default 6: attack recovery duration, in ticks.
- `FACING_RIGHT`, default 1: 1 means `fwd` increases x; 0 means `fwd` decreases x.

Ports:
- `clk`  in  1  system clock; the single clock of the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle frame strobe; all motion advances only on cycles with `tick`=1.
- `fwd`, `bwd`, `attack`, `up`  in  1 each  key levels from the keypad scanner, synchronous to `clk`.
- `pos_x`  out  10  fighter x position.
- `pos_y`  out  8  height above the ground; 0 means grounded.
- `state`  out  3  current state: IDLE=0, WALK=1, JUMP_UP=2, JUMP_DN=3, WINDUP=4, HIT=5, RECOVER=6.
- `hit_active`  out  1  high exactly while `state`=HIT.
- `busy`  out  1  high in every state except IDLE and WALK.

## Operation
- **Reset (`rst_n`=0, asynchronous):**
  - `pos_x`=X_INIT, `pos_y`=0, `state`=IDLE, `hit_active`=0, `busy`=0.
  - Internal registers clear: attack edge latch = 0, `attack` delay register = 0, tick counter = 0.
- **Attack edge detect:**
  - Every cycle, `attack_d` <= `attack`.
  - `attack` & ~`attack_d` sets `atk_req`.
  - `atk_req` clears on every tick, whether consumed or discarded. Holding `attack` therefore never retriggers.
  - An edge in the same cycle as `tick` counts for that tick.
- **Horizontal direction:** `dir` is +1 when exactly one key is held, either (`fwd` with FACING_RIGHT=1) or (`bwd` with FACING_RIGHT=0). `dir` is −1 for the mirrored case. `dir` is 0 if neither key or both keys are held.
- **Grounded states (IDLE, WALK), on tick, in priority order:**
  1. `atk_req` → WINDUP; tick counter = 0.
  2. `up` → JUMP_UP.
  3. `dir`≠0 → WALK and x moves.
  4. Otherwise → IDLE.
- **JUMP_UP, on tick:**
  - `pos_y` += JUMP_STEP, saturating at JUMP_H.
  - When the result equals JUMP_H → JUMP_DN.
- **JUMP_DN, on tick:**
  - `pos_y` −= JUMP_STEP, saturating at 0.
  - When the result is 0 → IDLE.
- **Air control:** x moves by `dir` during both jump states. `attack` and `up` are ignored while airborne.
- **Attack states:**
  - WINDUP, HIT and RECOVER each count ticks and exit when the count reaches WINDUP_T, ACTIVE_T or RECOVER_T respectively.
  - Sequence: WINDUP→HIT→RECOVER→IDLE. The counter resets on each transition.
  - No x movement; all keys are ignored.
- **X arithmetic:**
  - Moving +: `pos_x` = (`pos_x` > X_MAX−STEP) ? X_MAX : `pos_x`+STEP.
  - Moving −: `pos_x` = (`pos_x` < X_MIN+STEP) ? X_MIN : `pos_x`−STEP.
  - No wrap-around. Compare in 11 bits.
- **Y arithmetic:** same saturating rule against 0 and JUMP_H.

## Timing
- All outputs are registered. A tick sampled at edge k produces updated outputs after edge k; there is one cycle of latency from `tick` to outputs.
- Cycles without `tick`: outputs hold. Only `attack_d` and `atk_req` update.
- Attack entered on tick n:
  - `hit_active` rises after tick n+WINDUP_T and falls after tick n+WINDUP_T+ACTIVE_T.
  - IDLE is reached after tick n+13 with default parameters.
- Jump with default parameters: 16 ticks up, 16 ticks down; grounded again after 32 ticks.
- Reset asserted mid-jump or mid-attack forces the reset values immediately, with no completion of the action. The first tick after release is handled from IDLE.
- `tick` on consecutive cycles is legal; each one is a full frame step.

## Test plan
- **Reset and walk:** reset; hold `fwd` for 5 ticks (FACING_RIGHT=1) → `pos_x` reads 100, then 110; `state`=WALK; release → IDLE on next tick.
- **Clamp:** start at X_MIN; hold `bwd` for 3 ticks → `pos_x` stays 0. Walk to 599 with STEP=2 → 600, then holds at 600.
- **Attack edge and timing:** pulse `attack` between ticks, then tick n → WINDUP; `hit_active`=1 only after ticks n+3 through n+6; IDLE after n+13. Holding `attack` for 30 ticks → exactly one attack.
- **Priority:** `attack` edge, `up` and `fwd` all together at a tick → WINDUP, and `pos_x` unchanged. `fwd`+`bwd` held → IDLE, and `pos_x` unchanged.
- **Jump with air control:** `up` plus held `fwd` → `pos_y` 4,8,…,64 then 60,…,0; `pos_x` +64 over the 32 ticks; `attack` pressed mid-air ignored.
- **Async reset mid-attack:** assert `rst_n`=0 in HIT between clock edges → `hit_active`=0 and `state`=IDLE without a clock; `pos_x`=100.
